// File: rtl/fifo_rr_drain_sched.sv
// rtl/fifo_rr_drain_sched.sv - round-robin drain scheduler for four capture FIFOs
//
// Drains the four capture FIFOs in round-robin order. Each word read is tagged
// with its channel number and a free-running cycle timestamp, then handed to the
// uplink through a 2-entry skid buffer. Sustains one word per cycle.
//
// Optional feature macro: SCHED_STATS_EN (per-channel grant counters).
//
// Ports:
//   clk         in   system clock, posedge
//   rst         in   asynchronous reset, active-high
//   sched_en    in   1 = issue new reads, 0 = only finish in-flight/buffered words
//   fifo_empty  in   [3:0] registered empty flags of the FIFOs
//   fifo_rdreq  out  [3:0] one-hot read strobe
//   fifo_q      in   [4*DW-1:0] FIFO i data on [DW*i +: DW], valid 1 cycle after rdreq
//   up_ready    in   downstream ready
//   data_valid  out  up_data holds a valid word
//   up_data     out  [63:0] {ch[1:0], ts[TSW-1:0], data[DW-1:0]}
//   busy        out  read in flight or skid buffer non-empty
//   stats_clr   in   (SCHED_STATS_EN) zero all grant counters
//   grant_cnt   out  (SCHED_STATS_EN) [63:0] ch i grant count on [16*i +: 16]
module fifo_rr_drain_sched #(
    parameter int DW  = 32,
    parameter int TSW = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sched_en,
    input  logic [3:0]      fifo_empty,
    output logic [3:0]      fifo_rdreq,
    input  logic [4*DW-1:0] fifo_q,
    input  logic            up_ready,
    output logic            data_valid,
    output logic [63:0]     up_data,
    output logic            busy
`ifdef SCHED_STATS_EN
    ,
    input  logic            stats_clr,
    output logic [63:0]     grant_cnt
`endif
);

    logic [TSW-1:0] ts;
    logic [1:0]     ptr;
    logic [3:0]     last_rd;
    logic           inflight;
    logic [1:0]     tag_ch;
    logic [TSW-1:0] tag_ts;

    logic [63:0]    skid_mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     skid_cnt;

    logic [3:0]     eligible;
    logic           grant_vld;
    logic [1:0]     grant_ch;
    logic [1:0]     cand;
    logic [1:0]     occ;
    logic           credit_ok;
    logic           do_grant;
    logic           pop;
    logic           push;
    logic [DW-1:0]  cap_data;

    assign pop        = data_valid & up_ready;
    assign push       = inflight;
    assign data_valid = (skid_cnt != 2'd0);
    assign up_data    = skid_mem[rd_ptr];
    assign busy       = inflight | data_valid;
    assign cap_data   = fifo_q[DW*tag_ch +: DW];

    // A channel read last cycle is masked: its empty flag does not yet reflect
    // that read, so granting it again could underflow the FIFO.
    assign eligible = ~fifo_empty & ~last_rd;

    // Occupancy counts the word leaving this cycle, so a pop frees a slot for
    // a same-cycle grant. That is what keeps one word per cycle flowing while
    // still guaranteeing the buffer cannot overflow.
    assign occ       = skid_cnt - {1'b0, pop} + {1'b0, inflight};
    assign credit_ok = (occ < 2'd2);

    // First eligible channel at or above ptr, wrapping mod 4. Scanning the
    // offsets downward lets the smallest offset win.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = ptr;
        cand      = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + k[1:0];
            if (eligible[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    // Strobe is combinational; holding it low during rst makes reset take
    // effect on the read port immediately.
    assign do_grant   = ~rst & sched_en & credit_ok & grant_vld;
    assign fifo_rdreq = do_grant ? (4'b0001 << grant_ch) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts          <= '0;
            ptr         <= 2'd0;
            last_rd     <= 4'b0000;
            inflight    <= 1'b0;
            tag_ch      <= 2'd0;
            tag_ts      <= '0;
            skid_mem[0] <= 64'd0;
            skid_mem[1] <= 64'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            ts       <= ts + 1'b1;
            last_rd  <= fifo_rdreq;
            inflight <= do_grant;
            if (do_grant) begin
                ptr    <= grant_ch + 2'd1;
                tag_ch <= grant_ch;
                tag_ts <= ts;
            end
            if (push) begin
                skid_mem[wr_ptr] <= {tag_ch, tag_ts, cap_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] gcnt [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                gcnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stats_clr) begin
                    gcnt[i] <= 16'd0;
                end else if (fifo_rdreq[i]) begin
                    gcnt[i] <= gcnt[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = {gcnt[3], gcnt[2], gcnt[1], gcnt[0]};
`endif

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// tb/tb_fifo_rr_drain_sched.sv - directed self-checking bench for fifo_rr_drain_sched
module tb_fifo_rr_drain_sched;

    logic          clk = 1'b0;
    logic          rst;
    logic          sched_en;
    logic [3:0]    fifo_empty;
    logic [3:0]    fifo_rdreq;
    logic [127:0]  fifo_q;
    logic          up_ready;
    logic          data_valid;
    logic [63:0]   up_data;
    logic          busy;
`ifdef SCHED_STATS_EN
    logic          stats_clr;
    logic [63:0]   grant_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rr_drain_sched #(.DW(32), .TSW(30)) dut (
        .clk        (clk),
        .rst        (rst),
        .sched_en   (sched_en),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .fifo_q     (fifo_q),
        .up_ready   (up_ready),
        .data_valid (data_valid),
        .up_data    (up_data),
        .busy       (busy)
`ifdef SCHED_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // FIFO contents model
    logic [31:0] fmem [4][16];
    int          fhead [4] = '{0, 0, 0, 0};
    int          ftail [4] = '{0, 0, 0, 0};

    // logs
    logic [63:0] exp_q [$];
    logic [63:0] out_log [$];
    int          out_cyc [$];
    int          gch_log [$];
    int          gcyc_log [$];
    logic        busy_hist [256];

    logic [3:0]  prev_rd = 4'b0000;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = 64'd0;
    int          cyc = 0;
    logic [29:0] ts_model = 30'd0;

    function automatic logic fifos_nonempty();
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ftail[i] != fhead[i]) r = 1'b1;
        end
        return r;
    endfunction

    // FIFO read port: data one cycle after rdreq; empty flag lags one read
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            logic was_empty;
            was_empty = (ftail[i] == fhead[i]);
            if (prev_rd[i] && !was_empty) begin
                fifo_q[32*i +: 32] = fmem[i][fhead[i]];
                fhead[i] = fhead[i] + 1;
            end
            fifo_empty[i] = was_empty;
        end
    end

    // Monitor sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            cyc        = 0;
            ts_model   = 30'd0;
            prev_rd    = 4'b0000;
            prev_stall = 1'b0;
        end else begin
            checks++;
            if ($countones(fifo_rdreq) > 1) begin
                failures++;
                $display("FAIL rdreq_onehot cyc=%0d got=%b exp=at most one bit", cyc, fifo_rdreq);
            end
            for (int i = 0; i < 4; i++) begin
                if (fifo_rdreq[i]) begin
                    checks++;
                    if (prev_rd[i]) begin
                        failures++;
                        $display("FAIL back_to_back ch=%0d cyc=%0d got=consecutive exp=gap", i, cyc);
                    end
                    checks++;
                    if (ftail[i] == fhead[i]) begin
                        failures++;
                        $display("FAIL underflow ch=%0d cyc=%0d got=read of empty exp=no read", i, cyc);
                    end else begin
                        exp_q.push_back({i[1:0], ts_model, fmem[i][fhead[i]]});
                    end
                    gch_log.push_back(i);
                    gcyc_log.push_back(cyc);
                end
            end
            if (prev_stall) begin
                checks++;
                if (data_valid !== 1'b1 || up_data !== prev_data) begin
                    failures++;
                    $display("FAIL hold_stable cyc=%0d got=%b/%h exp=1/%h", cyc, data_valid, up_data, prev_data);
                end
            end
            if (data_valid && up_ready) begin
                out_log.push_back(up_data);
                out_cyc.push_back(cyc);
            end
            if (cyc < 256) busy_hist[cyc] = busy;
            prev_stall = data_valid && !up_ready;
            prev_data  = up_data;
            prev_rd    = fifo_rdreq;
            ts_model   = ts_model + 30'd1;
            cyc++;
        end
    end

    // Hold reset, load FIFOs, release at posedge+1 (that cycle is cycle 0)
    task automatic do_reset_load(input int n0, input int n1, input int n2, input int n3,
                                 input logic en, input logic rdy);
        int n [4];
        n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
        rst = 1'b1;
        sched_en = en;
        up_ready = rdy;
        for (int c = 0; c < 4; c++) begin
            fhead[c] = 0;
            ftail[c] = n[c];
            for (int k = 0; k < 16; k++) begin
                fmem[c][k] = 32'hA0000000 + c * 256 + k;
            end
        end
        exp_q.delete(); out_log.delete(); out_cyc.delete();
        gch_log.delete(); gcyc_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((fifos_nonempty() || busy) && n < budget);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout got=%0d cycles exp=<%0d", n, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fifo_rdreq !== 4'b0000) begin failures++; $display("FAIL reset_rdreq got=%b exp=0000", fifo_rdreq); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
        checks++; if (up_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", up_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        do_reset_load(0, 0, 0, 0, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (gch_log.size() != 0) begin failures++; $display("FAIL all_empty_grants got=%0d exp=0", gch_log.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL all_empty_busy got=%b exp=0", busy); end
    endtask

    task automatic test_rr_order();
        do_reset_load(3, 3, 3, 3, 1'b1, 1'b1);
        wait_drain(60);
        checks++; if (gch_log.size() != 12) begin failures++; $display("FAIL rr_grant_count got=%0d exp=12", gch_log.size()); end
        for (int k = 0; k < 12 && k < gch_log.size(); k++) begin
            checks++; if (gch_log[k] != k % 4) begin failures++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, gch_log[k], k % 4); end
            checks++; if (gcyc_log[k] != k) begin failures++; $display("FAIL rr_grant_cyc k=%0d got=%0d exp=%0d", k, gcyc_log[k], k); end
        end
        checks++; if (out_log.size() != 12) begin failures++; $display("FAIL rr_out_count got=%0d exp=12", out_log.size()); end
        for (int k = 0; k < 12 && k < out_log.size(); k++) begin
            logic [63:0] w;
            w = {k[1:0], k[29:0], 32'hA0000000 + (k % 4) * 256 + k / 4};
            checks++; if (out_cyc[k] != k + 2) begin failures++; $display("FAIL rr_out_cyc k=%0d got=%0d exp=%0d", k, out_cyc[k], k + 2); end
            checks++; if (out_log[k] !== w) begin failures++; $display("FAIL rr_out_word k=%0d got=%h exp=%h", k, out_log[k], w); end
        end
    endtask

    task automatic test_single_channel();
        do_reset_load(0, 0, 4, 0, 1'b1, 1'b1);
        wait_drain(40);
        checks++; if (gch_log.size() != 4) begin failures++; $display("FAIL single_grants got=%0d exp=4", gch_log.size()); end
        for (int k = 0; k < 4 && k < gch_log.size(); k++) begin
            checks++; if (gch_log[k] != 2 || gcyc_log[k] != 2 * k) begin
                failures++; $display("FAIL single_grant k=%0d got=ch%0d@%0d exp=ch2@%0d", k, gch_log[k], gcyc_log[k], 2 * k);
            end
        end
        checks++; if (out_log.size() != 4) begin failures++; $display("FAIL single_outs got=%0d exp=4", out_log.size()); end
        for (int k = 0; k < 4 && k < out_log.size(); k++) begin
            logic [63:0] w;
            w = {2'd2, 30'(2 * k), 32'hA0000200 + k};
            checks++; if (out_log[k] !== w) begin failures++; $display("FAIL single_word k=%0d got=%h exp=%h", k, out_log[k], w); end
        end
    endtask

    task automatic test_ts_wrap();
        logic [29:0] ets [3];
        ets[0] = 30'h3FFFFFFE; ets[1] = 30'h3FFFFFFF; ets[2] = 30'h0;
        do_reset_load(1, 1, 1, 0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        force dut.ts = 30'h3FFFFFFE;
        ts_model = 30'h3FFFFFFE;
        sched_en = 1'b1;
        #1;
        release dut.ts;
        wait_drain(30);
        checks++; if (out_log.size() != 3) begin failures++; $display("FAIL wrap_outs got=%0d exp=3", out_log.size()); end
        for (int k = 0; k < 3 && k < out_log.size(); k++) begin
            checks++; if (out_log[k][61:32] !== ets[k]) begin failures++; $display("FAIL wrap_ts k=%0d got=%h exp=%h", k, out_log[k][61:32], ets[k]); end
            checks++; if (out_log[k][63:62] !== k[1:0]) begin failures++; $display("FAIL wrap_ch k=%0d got=%0d exp=%0d", k, out_log[k][63:62], k); end
        end
        checks++; if (gcyc_log.size() == 3 && (gcyc_log[1] != gcyc_log[0] + 1 || gcyc_log[2] != gcyc_log[0] + 2)) begin
            failures++; $display("FAIL wrap_consecutive got=%0d,%0d,%0d exp=consecutive", gcyc_log[0], gcyc_log[1], gcyc_log[2]);
        end
    endtask

    task automatic test_backpressure();
        int seen [4];
        do_reset_load(3, 3, 3, 3, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (gch_log.size() != 2) begin failures++; $display("FAIL bp_grants got=%0d exp=2", gch_log.size()); end
        checks++; if (data_valid !== 1'b1) begin failures++; $display("FAIL bp_dv got=%b exp=1", data_valid); end
        checks++; if (up_data !== {2'd0, 30'd0, 32'hA0000000}) begin failures++; $display("FAIL bp_head got=%h exp=%h", up_data, {2'd0, 30'd0, 32'hA0000000}); end
        up_ready = 1'b1;
        wait_drain(80);
        checks++; if (out_log.size() != 12) begin failures++; $display("FAIL bp_outs got=%0d exp=12", out_log.size()); end
        for (int c = 0; c < 4; c++) seen[c] = 0;
        for (int k = 0; k < out_log.size() && k < exp_q.size(); k++) begin
            int c;
            c = int'(out_log[k][63:62]);
            checks++; if (out_log[k][31:0] !== 32'hA0000000 + c * 256 + seen[c]) begin
                failures++; $display("FAIL bp_data k=%0d got=%h exp=%h", k, out_log[k][31:0], 32'hA0000000 + c * 256 + seen[c]);
            end
            seen[c]++;
            checks++; if (out_log[k] !== exp_q[k]) begin failures++; $display("FAIL bp_word k=%0d got=%h exp=%h", k, out_log[k], exp_q[k]); end
        end
    endtask

    task automatic test_sched_disable();
        do_reset_load(0, 3, 0, 0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        sched_en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (gch_log.size() != 1) begin failures++; $display("FAIL dis_grants got=%0d exp=1", gch_log.size()); end
        checks++; if (out_log.size() != 1) begin failures++; $display("FAIL dis_outs got=%0d exp=1", out_log.size()); end
        if (out_log.size() == 1) begin
            checks++; if (out_log[0] !== {2'd1, 30'd0, 32'hA0000100}) begin failures++; $display("FAIL dis_word got=%h exp=%h", out_log[0], {2'd1, 30'd0, 32'hA0000100}); end
            checks++; if (out_cyc[0] != 2) begin failures++; $display("FAIL dis_out_cyc got=%0d exp=2", out_cyc[0]); end
        end
        checks++; if (busy_hist[1] !== 1'b1 || busy_hist[2] !== 1'b1) begin failures++; $display("FAIL dis_busy_on got=%b%b exp=11", busy_hist[1], busy_hist[2]); end
        checks++; if (busy_hist[3] !== 1'b0) begin failures++; $display("FAIL dis_busy_off got=%b exp=0", busy_hist[3]); end
    endtask

    task automatic test_reset_mid();
        do_reset_load(3, 3, 3, 3, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (data_valid !== 1'b1 || gch_log.size() != 2) begin failures++; $display("FAIL mid_full got=%b/%0d exp=1/2", data_valid, gch_log.size()); end
        rst = 1'b1;
        #1;
        checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_dv got=%b exp=0", data_valid); end
        checks++; if (up_data !== 64'd0) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", up_data); end
        checks++; if (fifo_rdreq !== 4'b0000) begin failures++; $display("FAIL mid_rst_rdreq got=%b exp=0000", fifo_rdreq); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
`ifdef SCHED_STATS_EN
        checks++; if (grant_cnt !== 64'd0) begin failures++; $display("FAIL mid_rst_cnt got=%h exp=0", grant_cnt); end
`endif
        up_ready = 1'b1;
        exp_q.delete(); out_log.delete(); out_cyc.delete();
        gch_log.delete(); gcyc_log.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (gch_log.size() < 1 || gch_log[0] != 0 || gcyc_log[0] != 0) begin
            failures++; $display("FAIL mid_first_grant got=%0d exp=ch0@0", gch_log.size() > 0 ? gch_log[0] : -1);
        end
`ifdef SCHED_STATS_EN
        checks++; if (grant_cnt !== 64'd1) begin failures++; $display("FAIL mid_cnt_ch0 got=%h exp=1", grant_cnt); end
`endif
        wait_drain(80);
        checks++; if (out_log.size() != 10) begin failures++; $display("FAIL mid_outs got=%0d exp=10", out_log.size()); end
        for (int k = 0; k < out_log.size() && k < exp_q.size(); k++) begin
            checks++; if (out_log[k] !== exp_q[k]) begin failures++; $display("FAIL mid_word k=%0d got=%h exp=%h", k, out_log[k], exp_q[k]); end
        end
`ifdef SCHED_STATS_EN
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        checks++; if (grant_cnt !== 64'd0) begin failures++; $display("FAIL stats_clr got=%h exp=0", grant_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        sched_en = 1'b0;
        up_ready = 1'b0;
        fifo_empty = 4'hF;
        fifo_q = '0;
`ifdef SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_rr_order();
        test_single_channel();
        test_ts_wrap();
        test_backpressure();
        test_sched_disable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
